edac_nx4bit_seq: RTL and testbench
==================================

# edac_nx4bit_seq

Parametrised, time-multiplexed EDAC engine for CHANNELS nibble lanes. It encodes 4-bit nibbles into 16-bit duplicated CRC-4 codewords, or decodes and corrects such codewords. A single shared CRC/decision datapath processes one channel per clock under a start/busy/done handshake. It sits between the memory interface and the core and replaces fixed-width dual-channel EDAC wrappers.

## Interface
- CHANNELS, 2, number of nibble lanes; 1..8.
- CRC, 4'h9, CRC-4 polynomial low bits; x^4 is implicit.
- ERROR_CODE, all ones (16*CHANNELS bits), DOUT value on uncorrectable read.
- CLK  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  engine enable; low freezes RUN.
- start  in  1  request; sampled in IDLE only.
- READ  in  1  mode latched with start: 1 = decode, 0 = encode.
- DIN  in  16*CHANNELS  codewords (read) or nibbles in [4*CHANNELS-1:0] (write).
- cnt_clr  in  1  synchronous clear of error counters.
- busy  out  1  high from accept through final assembly.
- done  out  1  one-cycle pulse when DOUT/err/corr are updated.
- DOUT  out  16*CHANNELS  registered result.
- err  out  1  last read had an uncorrectable channel.
- corr  out  1  last read corrected at least one channel.
- corr_cnt  out  16  corrected-channel event count, saturating.
- uncorr_cnt  out  16  uncorrectable-channel event count, saturating.

## Operation
- crc4(d): MSB-first, init 0; per bit b: fb = c[3]^b, c = {c[2:0],0} ^ (fb ? CRC : 0). Examples: crc4(A)=C, crc4(5)=6, crc4(0)=0.
- Half = {d, crc4(d)}. Codeword = {half, half}: H = cw[15:8], L = cw[7:0]. A half is good when its check equals crc4 of its nibble.
- Encode: channel i nibble DIN[4i+3:4i] -> DOUT[16i+15:16i]. err = corr = 0.
- Decode, per channel:
  - both halves good, nibbles equal -> clean.
  - exactly one half good -> use it; corrected.
  - both good but different, or neither good -> uncorrectable.
- Decode output: DOUT[4i+3:4i] = nibble i, all higher bits 0. Any uncorrectable channel -> DOUT = ERROR_CODE.
- FSM IDLE -> RUN -> ASM -> IDLE:
  - IDLE: start & en latches DIN and READ, sets idx = 0, goes to RUN.
  - RUN: processes channel idx into a staging register; moves to ASM after idx = CHANNELS-1.
  - ASM: loads DOUT, err, corr; pulses done; returns to IDLE.
- start while busy is ignored. DIN changes after accept have no effect.

## Timing
- Reset values: all outputs 0, state IDLE, idx 0, staging cleared.
- Accept at edge E0; busy = 1 after E0. Channel k is processed at edge E(k+1).
- DOUT, err, corr and done are updated at E(CHANNELS+1). busy falls at the same edge. Latency is CHANNELS+1 cycles.
- done falls at the next edge unconditionally. DOUT, err and corr hold until the next ASM.
- en = 0 in RUN: idx and staging hold, busy stays 1, latency stretches by the stalled cycles. en is ignored in ASM.
- Back-to-back: a start in the cycle after done is accepted.
- reset mid-operation: immediate return to IDLE; the partial result is discarded and DOUT = 0.
- Counters: +1 per corrected or uncorrectable channel at that channel's RUN edge, saturating at FFFF. cnt_clr has priority over a same-cycle increment.

## Configuration
- EDAC_ERR_CNT_EN defined: corr_cnt and uncorr_cnt are implemented as above.
- Undefined: the counter registers are removed. Ports remain and are tied to 0; cnt_clr is ignored. err, corr and DOUT are unaffected.

## Test plan
- Write, CHANNELS=2, DIN=0x0000005A -> done pulse 3 cycles after accept, DOUT=0x5656ACAC, err=0, corr=0.
- Read DIN=0x5656ACAC -> DOUT=0x0000005A, err=0, corr=0, counters unchanged.
- Read DIN=0x5656ACAD (ch0 low-half bit flip) -> DOUT=0x0000005A, corr=1, corr_cnt=1 (macro on) / 0 (macro off).
- Read DIN=0x5600ACAC (ch1 halves both good, nibbles 5 vs 0) -> DOUT=0xFFFFFFFF, err=1, uncorr_cnt=1.
- en low for 2 cycles in RUN -> done 5 cycles after accept. A start pulse while busy is ignored. reset asserted mid-RUN -> busy=0 and DOUT=0 immediately, no done.
- With the macro on, 65536 corrected events -> corr_cnt holds FFFF. cnt_clr asserted with a same-cycle event -> corr_cnt=0.

Source files
------------

// File: rtl/edac_nx4bit_seq.sv
// edac_nx4bit_seq: time-multiplexed EDAC engine for CHANNELS nibble lanes.
// Encodes 4-bit nibbles into 16-bit duplicated CRC-4 codewords {half, half},
// half = {nibble, crc4(nibble)}, or decodes/corrects such codewords. One shared
// CRC/decision datapath handles one channel per clock (start/busy/done).
//
// Optional feature macro: EDAC_ERR_CNT_EN
//   defined   -> saturating corr_cnt/uncorr_cnt event counters implemented
//   undefined -> counters removed, ports tied to 0, cnt_clr ignored
//
// Ports:
//   CLK        in   system clock, rising edge
//   reset      in   asynchronous active-high reset
//   en         in   engine enable; low stalls RUN
//   start      in   request, sampled in IDLE only
//   READ       in   latched with start: 1 = decode, 0 = encode
//   DIN        in   codewords (read) or nibbles in [4*CHANNELS-1:0] (write)
//   cnt_clr    in   synchronous clear of the error counters
//   busy       out  high from accept through final assembly
//   done       out  one-cycle pulse when DOUT/err/corr update
//   DOUT       out  registered result
//   err        out  last read had an uncorrectable channel
//   corr       out  last read corrected at least one channel
//   corr_cnt   out  corrected-channel events, saturating
//   uncorr_cnt out  uncorrectable-channel events, saturating
module edac_nx4bit_seq #(
  parameter int unsigned            CHANNELS   = 2,
  parameter logic [3:0]             CRC        = 4'h9,
  parameter logic [16*CHANNELS-1:0] ERROR_CODE = '1
) (
  input  logic                    CLK,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    start,
  input  logic                    READ,
  input  logic [16*CHANNELS-1:0]  DIN,
  input  logic                    cnt_clr,
  output logic                    busy,
  output logic                    done,
  output logic [16*CHANNELS-1:0]  DOUT,
  output logic                    err,
  output logic                    corr,
  output logic [15:0]             corr_cnt,
  output logic [15:0]             uncorr_cnt
);

  localparam int unsigned W    = 16 * CHANNELS;
  localparam int unsigned IdxW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StAsm} state_e;

  // MSB-first CRC-4, init 0, x^4 implicit.
  function automatic logic [3:0] crc4(input logic [3:0] d);
    logic [3:0] c;
    logic       fb;
    c = 4'h0;
    for (int b = 3; b >= 0; b--) begin
      fb = c[3] ^ d[b];
      c  = {c[2:0], 1'b0} ^ (fb ? CRC : 4'h0);
    end
    return c;
  endfunction

  state_e          state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            read_q, read_d;
  logic [W-1:0]    din_q, din_d;
  logic [W-1:0]    stage_q, stage_d;
  logic            any_corr_q, any_corr_d;
  logic            any_uncorr_q, any_uncorr_d;
  logic [W-1:0]    dout_q, dout_d;
  logic            err_q, err_d;
  logic            corr_q, corr_d;
  logic            done_q, done_d;

  // Shared per-channel datapath, fed by the channel selected by idx_q.
  logic [15:0] cw;
  logic [3:0]  nib_in;
  logic [7:0]  half_h, half_l;
  logic        h_good, l_good;
  logic        ch_corr, ch_uncorr;
  logic [3:0]  ch_nib;
  logic [7:0]  enc_half;
  logic        last_ch;

  always_comb begin
    cw     = '0;
    nib_in = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (idx_q == IdxW'(i)) begin
        cw     = din_q[16*i +: 16];
        nib_in = din_q[4*i +: 4];
      end
    end
    half_h    = cw[15:8];
    half_l    = cw[7:0];
    h_good    = (crc4(half_h[7:4]) == half_h[3:0]);
    l_good    = (crc4(half_l[7:4]) == half_l[3:0]);
    ch_corr   = h_good ^ l_good;
    ch_uncorr = (!h_good && !l_good) || (h_good && l_good && (half_h[7:4] != half_l[7:4]));
    ch_nib    = h_good ? half_h[7:4] : half_l[7:4];
    enc_half  = {nib_in, crc4(nib_in)};
    last_ch   = (idx_q == IdxW'(CHANNELS - 1));
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    read_d       = read_q;
    din_d        = din_q;
    stage_d      = stage_q;
    any_corr_d   = any_corr_q;
    any_uncorr_d = any_uncorr_q;
    dout_d       = dout_q;
    err_d        = err_q;
    corr_d       = corr_q;
    done_d       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start && en) begin
          read_d       = READ;
          din_d        = DIN;
          idx_d        = '0;
          stage_d      = '0;
          any_corr_d   = 1'b0;
          any_uncorr_d = 1'b0;
          state_d      = StRun;
        end
      end
      StRun: begin
        if (en) begin
          for (int i = 0; i < CHANNELS; i++) begin
            if (idx_q == IdxW'(i)) begin
              if (read_q) stage_d[4*i +: 4]   = ch_nib;
              else        stage_d[16*i +: 16] = {enc_half, enc_half};
            end
          end
          if (read_q) begin
            any_corr_d   = any_corr_q | ch_corr;
            any_uncorr_d = any_uncorr_q | ch_uncorr;
          end
          if (last_ch) state_d = StAsm;
          else         idx_d   = idx_q + 1'b1;
        end
      end
      StAsm: begin
        // en is deliberately ignored here so assembly always completes.
        done_d  = 1'b1;
        state_d = StIdle;
        if (read_q) begin
          dout_d = any_uncorr_q ? ERROR_CODE : stage_q;
          err_d  = any_uncorr_q;
          corr_d = any_corr_q;
        end else begin
          dout_d = stage_q;
          err_d  = 1'b0;
          corr_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      read_q       <= 1'b0;
      din_q        <= '0;
      stage_q      <= '0;
      any_corr_q   <= 1'b0;
      any_uncorr_q <= 1'b0;
      dout_q       <= '0;
      err_q        <= 1'b0;
      corr_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      read_q       <= read_d;
      din_q        <= din_d;
      stage_q      <= stage_d;
      any_corr_q   <= any_corr_d;
      any_uncorr_q <= any_uncorr_d;
      dout_q       <= dout_d;
      err_q        <= err_d;
      corr_q       <= corr_d;
      done_q       <= done_d;
    end
  end

`ifdef EDAC_ERR_CNT_EN
  logic [15:0] corr_cnt_q, uncorr_cnt_q;
  logic        evt_corr, evt_uncorr;

  assign evt_corr   = (state_q == StRun) && en && read_q && ch_corr;
  assign evt_uncorr = (state_q == StRun) && en && read_q && ch_uncorr;

  // cnt_clr wins over a same-cycle event.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      corr_cnt_q   <= '0;
      uncorr_cnt_q <= '0;
    end else if (cnt_clr) begin
      corr_cnt_q   <= '0;
      uncorr_cnt_q <= '0;
    end else begin
      if (evt_corr && (corr_cnt_q != 16'hFFFF))     corr_cnt_q   <= corr_cnt_q + 16'd1;
      if (evt_uncorr && (uncorr_cnt_q != 16'hFFFF)) uncorr_cnt_q <= uncorr_cnt_q + 16'd1;
    end
  end

  assign corr_cnt   = corr_cnt_q;
  assign uncorr_cnt = uncorr_cnt_q;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign corr_cnt       = 16'h0000;
  assign uncorr_cnt     = 16'h0000;
`endif

  assign busy = (state_q != StIdle);
  assign done = done_q;
  assign DOUT = dout_q;
  assign err  = err_q;
  assign corr = corr_q;

endmodule

// File: tb/tb_edac_nx4bit_seq.sv
// Directed scoreboard bench for edac_nx4bit_seq (2-channel and 8-channel instances).
module tb_edac_nx4bit_seq;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  // 2-channel instance
  logic        reset, en, start, READ, cnt_clr;
  logic [31:0] DIN;
  logic        busy, done, err, corr;
  logic [31:0] DOUT;
  logic [15:0] corr_cnt, uncorr_cnt;

  edac_nx4bit_seq #(.CHANNELS(2)) dut (
    .CLK(CLK), .reset(reset), .en(en), .start(start), .READ(READ), .DIN(DIN),
    .cnt_clr(cnt_clr), .busy(busy), .done(done), .DOUT(DOUT), .err(err), .corr(corr),
    .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt)
  );

  // 8-channel instance
  logic         en8, start8, read8, clr8;
  logic [127:0] din8;
  logic         busy8, done8, err8, corr8;
  logic [127:0] dout8;
  logic [15:0]  cc8, uc8;

  edac_nx4bit_seq #(.CHANNELS(8)) dut8 (
    .CLK(CLK), .reset(reset), .en(en8), .start(start8), .READ(read8), .DIN(din8),
    .cnt_clr(clr8), .busy(busy8), .done(done8), .DOUT(dout8), .err(err8), .corr(corr8),
    .corr_cnt(cc8), .uncorr_cnt(uc8)
  );

  int passed = 0;
  int total  = 0;
  int m_corr = 0;
  int m_uncorr = 0;

  typedef struct {
    logic [31:0] dout;
    logic        err;
    logic        corr;
    int          lat;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    total++;
    assert (act === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  // Drive one transaction, push its expectation, wait for done, pop and compare.
  task automatic run_op(input string tag, input logic rd, input logic [31:0] din,
                        input logic [31:0] e_dout, input logic e_err, input logic e_corr,
                        input int n_c, input int n_u, input int stall, input logic clr);
    exp_t e, got;
    int   lat;
    e = '{dout: e_dout, err: e_err, corr: e_corr, lat: 3 + stall};
    sb.push_back(e);
    cnt_clr = clr;
    READ    = rd;
    DIN     = din;
    start   = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    DIN   = ~din;
    chk({tag, " busy"}, {127'd0, busy}, 128'd1);
    lat = 0;
    while (!done && lat < 20) begin
      en    = (lat < stall) ? 1'b0 : 1'b1;
      start = (stall > 0 && lat == 1) ? 1'b1 : 1'b0;
      @(negedge CLK);
      lat++;
    end
    en    = 1'b1;
    start = 1'b0;
    got   = sb.pop_front();
    chk({tag, " lat"}, 128'(lat), 128'(got.lat));
    chk({tag, " dout"}, {96'd0, DOUT}, {96'd0, got.dout});
    chk({tag, " err"}, {127'd0, err}, {127'd0, got.err});
    chk({tag, " corr"}, {127'd0, corr}, {127'd0, got.corr});
    chk({tag, " busy_low"}, {127'd0, busy}, 128'd0);
`ifdef EDAC_ERR_CNT_EN
    if (clr) begin
      m_corr   = 0;
      m_uncorr = 0;
    end else begin
      m_corr   = m_corr + n_c;
      m_uncorr = m_uncorr + n_u;
    end
`endif
    chk({tag, " corr_cnt"}, {112'd0, corr_cnt}, 128'(m_corr));
    chk({tag, " uncorr_cnt"}, {112'd0, uncorr_cnt}, 128'(m_uncorr));
    cnt_clr = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1, "timeout");
  end

  initial begin
    int  lat;
    int  ndone;
    logic saw_done;
    reset = 1'b1; en = 1'b1; start = 1'b0; READ = 1'b0; cnt_clr = 1'b0; DIN = '0;
    en8 = 1'b1; start8 = 1'b0; read8 = 1'b0; clr8 = 1'b0; din8 = '0;
    @(negedge CLK);
    @(negedge CLK);
    chk("rst busy", {127'd0, busy}, 128'd0);
    chk("rst done", {127'd0, done}, 128'd0);
    chk("rst dout", {96'd0, DOUT}, 128'd0);
    chk("rst err_corr", {126'd0, err, corr}, 128'd0);
    chk("rst cnts", {96'd0, corr_cnt, uncorr_cnt}, 128'd0);
    reset = 1'b0;
    @(negedge CLK);

    // Back-to-back sequence: each op starts the cycle after the previous done.
    run_op("wr5a",     1'b0, 32'h0000005A, 32'h5656ACAC, 1'b0, 1'b0, 0, 0, 0, 1'b0);
    run_op("rd_clean", 1'b1, 32'h5656ACAC, 32'h0000005A, 1'b0, 1'b0, 0, 0, 0, 1'b0);
    run_op("rd_lflip", 1'b1, 32'h5656ACAD, 32'h0000005A, 1'b0, 1'b1, 1, 0, 0, 1'b0);
    run_op("rd_diff",  1'b1, 32'h5600ACAC, 32'hFFFFFFFF, 1'b1, 1'b0, 0, 1, 0, 1'b0);
    run_op("wr_stall", 1'b0, 32'h00000037, 32'h32327D7D, 1'b0, 1'b0, 0, 0, 2, 1'b0);
    run_op("rd_hflip", 1'b1, 32'h5756ACAC, 32'h0000005A, 1'b0, 1'b1, 1, 0, 0, 1'b0);
    run_op("rd_none",  1'b1, 32'h56560102, 32'hFFFFFFFF, 1'b1, 1'b0, 0, 1, 0, 1'b0);
    run_op("rd_mixed", 1'b1, 32'h56570102, 32'hFFFFFFFF, 1'b1, 1'b1, 1, 1, 0, 1'b0);
    run_op("rd_clr",   1'b1, 32'h5656ACAD, 32'h0000005A, 1'b0, 1'b1, 1, 0, 0, 1'b1);
    run_op("rd_after", 1'b1, 32'h5656ACAC, 32'h0000005A, 1'b0, 1'b0, 0, 0, 0, 1'b0);

    // Reset mid-RUN: immediate IDLE, result discarded, no done afterwards.
    READ = 1'b0; DIN = 32'h0000005A; start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    @(negedge CLK);
    reset = 1'b1;
    #1;
    chk("midrst busy", {127'd0, busy}, 128'd0);
    chk("midrst dout", {96'd0, DOUT}, 128'd0);
    chk("midrst done", {127'd0, done}, 128'd0);
    m_corr = 0; m_uncorr = 0;
    @(negedge CLK);
    reset = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      if (done) saw_done = 1'b1;
    end
    chk("midrst no_done", {127'd0, saw_done}, 128'd0);
    run_op("wr_recover", 1'b0, 32'h0000005A, 32'h5656ACAC, 1'b0, 1'b0, 0, 0, 0, 1'b0);

    // 8-channel encode: latency CHANNELS+1 = 9.
    read8 = 1'b0; din8 = {96'd0, 32'h5A5A5A5A}; start8 = 1'b1;
    @(negedge CLK);
    start8 = 1'b0;
    lat = 0;
    while (!done8 && lat < 30) begin
      @(negedge CLK);
      lat++;
    end
    chk("ch8 lat", 128'(lat), 128'd9);
    chk("ch8 dout", dout8, {4{32'h5656ACAC}});
    chk("ch8 err_corr", {126'd0, err8, corr8}, 128'd0);

`ifdef EDAC_ERR_CNT_EN
    // Saturation: 8 corrected events per op; 8192 ops = 65536 events.
    read8 = 1'b1; din8 = {8{16'h0001}}; start8 = 1'b1;
    ndone = 0;
    lat   = 0;
    while (ndone < 8192 && lat < 85000) begin
      @(negedge CLK);
      lat++;
      if (done8) begin
        ndone++;
        if (ndone == 8191) chk("sat pre", {112'd0, cc8}, 128'h0000FFF8);
      end
    end
    start8 = 1'b0;
    chk("sat ops", 128'(ndone), 128'd8192);
    chk("sat corr_cnt", {112'd0, cc8}, 128'h0000FFFF);
    chk("sat uncorr_cnt", {112'd0, uc8}, 128'd0);
    chk("sat dout", dout8, 128'd0);
    chk("sat corr", {127'd0, corr8}, 128'd1);
    start8 = 1'b1;
    @(negedge CLK);
    start8 = 1'b0;
    lat = 0;
    while (!done8 && lat < 30) begin
      @(negedge CLK);
      lat++;
    end
    chk("sat hold", {112'd0, cc8}, 128'h0000FFFF);
`else
    chk("ch8 cnts", {96'd0, cc8, uc8}, 128'd0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
